// File: rtl/sw_conditioner.sv
// Two-channel switch conditioner: sync, debounce, and one-cycle press/release pulses.
// Each channel is an independent copy of sw_cond_chan; no shared state.

module sw_cond_chan #(
   parameter int DB_CYCLES = 250000,
   parameter int CNT_W     = 18
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic level,
   output logic press,
   output logic rls
);
   // state encoding is {stable, counting}
   typedef enum logic [1:0] {
      LOW  = 2'b00,
      RISE = 2'b01,
      HIGH = 2'b10,
      FALL = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1, s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= LOW;
         cnt   <= '0;
         press <= 1'b0;
         rls   <= 1'b0;
      end else begin
         s1    <= sw;
         s2    <= s1;
         press <= 1'b0;
         rls   <= 1'b0;
         case (state)
            LOW: if (s2) begin
               state <= RISE;
               cnt   <= CNT_W'(1);
            end
            RISE: if (!s2) begin
               state <= LOW;
               cnt   <= '0;
            end else if (cnt == LAST) begin
               state <= HIGH;
               cnt   <= '0;
               press <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            HIGH: if (!s2) begin
               state <= FALL;
               cnt   <= CNT_W'(1);
            end
            FALL: if (s2) begin
               state <= HIGH;
               cnt   <= '0;
            end else if (cnt == LAST) begin
               state <= LOW;
               cnt   <= '0;
               rls   <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         endcase
      end
   end

   assign level = state[1];
endmodule

module sw_conditioner #(
   parameter int DB_CYCLES = 250000,
   parameter int CNT_W     = 18
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_r,
   input  logic sw_l,
   output logic level_r,
   output logic level_l,
   output logic press_r,
   output logic press_l,
   output logic release_r,
   output logic release_l
);
   localparam int NUM_LANES = 2;

   // lane 0 = right, lane 1 = left
   logic [NUM_LANES-1:0] sw_v, level_v, press_v, rls_v;

   assign sw_v = {sw_l, sw_r};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      sw_cond_chan #(
         .DB_CYCLES(DB_CYCLES),
         .CNT_W    (CNT_W)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .sw   (sw_v[i]),
         .level(level_v[i]),
         .press(press_v[i]),
         .rls  (rls_v[i])
      );
   end

   assign level_r   = level_v[0];
   assign level_l   = level_v[1];
   assign press_r   = press_v[0];
   assign press_l   = press_v[1];
   assign release_r = rls_v[0];
   assign release_l = rls_v[1];
endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner with DB_CYCLES=4; output vector is
// {level_r, press_r, release_r, level_l, press_l, release_l}.

module tb_sw_conditioner;
   logic clk, rst, sw_r, sw_l;
   logic level_r, level_l, press_r, press_l, release_r, release_l;
   int   total = 0;
   int   bad   = 0;

   sw_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .sw_r     (sw_r),
      .sw_l     (sw_l),
      .level_r  (level_r),
      .level_l  (level_l),
      .press_r  (press_r),
      .press_l  (press_l),
      .release_r(release_r),
      .release_l(release_l)
   );

   wire [5:0] obs = {level_r, press_r, release_r, level_l, press_l, release_l};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // one rising edge, then settle before sampling or driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b0;
      sw_r = 1'b0;
      sw_l = 1'b0;
      #2;
      chk("reset_async", obs, 6'b000_000);
      tick();
      tick();
      chk("reset_held", obs, 6'b000_000);
      rst = 1'b1;

      // clean press on right: pulse after edge 6
      sw_r = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("press_r_e%0d", k), obs,
             {(k >= 6), (k == 6), 1'b0, 3'b000});
      end

      // bounce on left 1,0,1,0,1 then hold; final rise sampled at step 5
      for (int j = 1; j <= 11; j++) begin
         sw_l = (j <= 5) ? ((j % 2) == 1) : 1'b1;
         tick();
         chk($sformatf("bounce_l_e%0d", j), obs,
             {3'b100, (j >= 10), (j == 10), 1'b0});
      end

      // release right, held low 10 cycles
      sw_r = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("rel_r_e%0d", k), obs,
             {(k < 6), 1'b0, (k == 6), 3'b100});
      end

      // release left so both channels are low
      sw_l = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("rel_l_e%0d", k), obs,
             {3'b000, (k < 6), 1'b0, (k == 6)});
      end

      // simultaneous press on both channels
      sw_r = 1'b1;
      sw_l = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("simul_e%0d", k), obs,
             {(k >= 6), (k == 6), 1'b0, (k >= 6), (k == 6), 1'b0});
      end

      // simultaneous release
      sw_r = 1'b0;
      sw_l = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("simrel_e%0d", k), obs,
             {(k < 6), 1'b0, (k == 6), (k < 6), 1'b0, (k == 6)});
      end

      // 3-cycle glitch on left must be rejected
      for (int k = 1; k <= 10; k++) begin
         sw_l = (k <= 3);
         tick();
         chk($sformatf("glitch_e%0d", k), obs, 6'b000_000);
      end

      // reset while right count is at 2 (after edge 4)
      sw_r = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("pre_rst_e%0d", k), obs, 6'b000_000);
      end
      rst = 1'b0;
      #1;
      chk("mid_rst_async", obs, 6'b000_000);
      tick();
      chk("mid_rst_held", obs, 6'b000_000);
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("post_rst_e%0d", k), obs,
             {(k >= 6), (k == 6), 1'b0, 3'b000});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
